// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath.
// States, opcodes, ALUop / ALU_control codes, mux select codes, imm decode.
package cpu_pkg;

    localparam int STATE_W    = 4;
    localparam int ALU_CTRL_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format follows the opcode alone, independent of state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] s;
        s = IMM_I;
        case (op)
            OP_STORE:  s = IMM_S;
            OP_BRANCH: s = IMM_B;
            OP_JAL:    s = IMM_J;
            default:   s = IMM_I;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decoded instruction fields and flags in,
// every select and write enable out. master = controller, slave = datapath.
interface multicycle_controller_if;
    import cpu_pkg::*;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  zero;
    logic                  mem_ready;
    logic                  PC_write;
    logic                  adr_select;
    logic                  mem_write;
    logic                  IR_write;
    logic [1:0]            result_select;
    logic [1:0]            ALU_srcA;
    logic [1:0]            ALU_srcB;
    logic [1:0]            imm_select;
    logic [ALU_CTRL_W-1:0] ALU_control;
    logic                  reg_write;
    logic                  illegal;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output PC_write, adr_select, mem_write, IR_write,
        output result_select, ALU_srcA, ALU_srcB, imm_select,
        output ALU_control, reg_write, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  PC_write, adr_select, mem_write, IR_write,
        input  result_select, ALU_srcA, ALU_srcB, imm_select,
        input  ALU_control, reg_write, illegal
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decode.
// Ports: aluop_i, funct3_i, funct7b5_i, op5_i (opcode[5]) -> alu_control_o.
module alu_decoder
    import cpu_pkg::*;
(
    input  aluop_e                aluop_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7b5_i,
    input  logic                  op5_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only means sub for R-type; addi uses it as imm bit
                    3'b000:  alu_control_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM (lw, sw, R, I, beq, jal) with mem_ready stalls.
// Ports: clock, reset (async active-low), bus (master: fields in, controls out).
// Option: MULTICYCLE_TRAP_EN adds a sticky ERROR state for illegal opcodes.
module multicycle_controller
    import cpu_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_e                state_q;
    state_e                state_d;
    aluop_e                aluop;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  pc_write;
    logic                  adr_sel;
    logic                  mem_wr;
    logic                  ir_write;
    logic                  reg_wr;
    logic                  illegal;
    logic [1:0]            res_sel;
    logic [1:0]            src_a;
    logic [1:0]            src_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pc_write = 1'b0;
        adr_sel  = 1'b0;
        mem_wr   = 1'b0;
        ir_write = 1'b0;
        reg_wr   = 1'b0;
        illegal  = 1'b0;
        res_sel  = RES_ALUOUT;
        src_a    = SRCA_PC;
        src_b    = SRCB_RS2;
        aluop    = ALUOP_ADD;
        unique case (state_q)
            S_FETCH: begin
                src_b    = SRCB_FOUR;
                res_sel  = RES_ALU;
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures the branch/jump target here
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
`ifdef MULTICYCLE_TRAP_EN
                    default:           state_d = S_ERROR;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_sel = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_sel = RES_RDATA;
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_sel = 1'b1;
                mem_wr  = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                src_a    = SRCA_RS1;
                aluop    = ALUOP_SUB;
                pc_write = bus.zero;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms old PC + 4
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
`ifdef MULTICYCLE_TRAP_EN
            S_ERROR: begin
                illegal = 1'b1;
                state_d = S_ERROR;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_dec (
        .aluop_i       (aluop),
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5),
        .op5_i         (bus.opcode[5]),
        .alu_control_o (alu_ctrl)
    );

    // While reset is low every output is forced idle, even the
    // combinational mem_ready/zero/opcode paths.
    assign bus.PC_write      = reset & pc_write;
    assign bus.adr_select    = reset & adr_sel;
    assign bus.mem_write     = reset & mem_wr;
    assign bus.IR_write      = reset & ir_write;
    assign bus.reg_write     = reset & reg_wr;
    assign bus.illegal       = reset & illegal;
    assign bus.result_select = reset ? res_sel : 2'b00;
    assign bus.ALU_srcA      = reset ? src_a : 2'b00;
    assign bus.ALU_srcB      = reset ? src_b : 2'b00;
    assign bus.imm_select    = reset ? imm_sel(bus.opcode) : 2'b00;
    assign bus.ALU_control   = reset ? alu_ctrl : '0;

endmodule
